stall_manager: RTL and testbench
================================

# stall_manager

Global stall/flush controller for the pipeline's buffer stages. It collects per-stage stall requests, the buffer-full indications (`to_stall_mgmt`) from every buffer stage, and external flush requests. It drives the single global `stall` and `flush` lines into all buffers, plus a `src_ready` backpressure signal to the pipeline source. It tracks buffer occupancy so the source is held off while buffers drain after a stall, and it forces a flush if a stall exceeds a timeout.

## Interface
- `NUM_STAGES`, 4, number of buffer stages and stall-request sources.
- `SLOTS`, 8, buffer depth per stage; caps the occupancy counter.
- `MAX_STALL`, 64, consecutive stall cycles before a forced flush.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall_req`  in  NUM_STAGES  per-stage stall request, level.
- `buf_full`  in  NUM_STAGES  buffer-full from each buffer stage.
- `flush_req`  in  1  external flush request, level.
- `src_valid`  in  1  source presenting data this cycle.
- `stall`  out  1  global stall to all buffers.
- `flush`  out  1  global flush to all buffers, one-cycle pulse.
- `src_ready`  out  1  source may advance.
- `stall_count`  out  $clog2(MAX_STALL+1)  cycles in the current or most recent stall.
- `timeout`  out  1  pulses together with a timeout-forced flush.

## Operation
- FSM states: RUN, STALL, DRAIN, FLUSH. All outputs are registered.
- Reset values:
  - state = RUN
  - `stall` = 0, `flush` = 0, `timeout` = 0
  - `src_ready` = 1
  - `stall_count` = 0, occupancy `occ` = 0
- RUN:
  - `stall` = 0, `src_ready` = 1.
  - If `flush_req`, go to FLUSH.
  - Else if `|stall_req`, go to STALL and clear `stall_count`.
- STALL:
  - `stall` = 1.
  - `stall_count` increments each cycle, saturating at MAX_STALL.
  - `occ` increments when `src_valid && src_ready && occ<SLOTS`.
  - `src_ready` = !(`|buf_full` || `occ`==SLOTS after update).
  - If `flush_req`, go to FLUSH.
  - Else if `stall_count`==MAX_STALL-1 and still stalled, go to FLUSH with `timeout`.
  - Else if `stall_req`==0, go to DRAIN if `occ`>0, otherwise go to RUN.
- DRAIN:
  - `stall` = 0, `src_ready` = 0.
  - `occ` decrements by 1 per cycle; go to RUN on the cycle it reaches 0.
  - `flush_req` goes to FLUSH.
  - `|stall_req` returns to STALL with `occ` retained and `stall_count` restarted from 0.
- FLUSH:
  - `flush` = 1 for exactly one cycle; `stall` = 0, `src_ready` = 0.
  - Clears `occ`; `stall_count` holds its value.
  - Always returns to RUN next cycle. A still-asserted `flush_req` re-enters FLUSH from RUN, giving a flush every other cycle.
- Priority in every state: `reset` > `flush_req` > timeout > `stall_req` > drain/run.
- `flush` and `stall` are never high in the same cycle.

## Timing
- Request-to-output latency is 1 cycle: `stall_req` rising at edge N gives `stall`=1 after edge N+1. The same holds for `flush_req` to `flush`.
- STALL-to-RUN with `occ`=k takes k DRAIN cycles plus one transition cycle. `src_ready` returns high on the edge that enters RUN.
- Timeout:
  - With MAX_STALL=64 and `stall_req` held continuously, `stall` is high for 64 cycles.
  - `flush` and `timeout` pulse on the following cycle.
- `buf_full` is sampled only in STALL; it is ignored elsewhere.
- `reset` mid-operation:
  - Next edge returns everything to reset values.
  - A pending `flush` pulse is dropped.
  - `occ` is cleared.

## Structure
- Package `stall_mgmt_pkg`:
  - `state_t` enum (RUN, STALL, DRAIN, FLUSH).
  - Default constants for SLOTS and MAX_STALL.
- Sub-module `sat_counter`: parameterised width/max saturating up/down counter with clear. Instantiated twice, once for `stall_count` and once for `occ`.
- Everything else lives in one always block for the FSM plus registered output logic.

## Test plan
- After reset, hold idle 5 cycles -> `stall`=0, `flush`=0, `src_ready`=1, `stall_count`=0.
- `stall_req`=4'b0010 for 3 cycles with `src_valid`=1 -> `stall` high 3 cycles starting 1 cycle later, `occ`=3, then 3 DRAIN cycles with `src_ready`=0, then RUN with `src_ready`=1.
- Stall with `src_valid`=1 for 10 cycles -> `occ` saturates at 8, `src_ready`=0 from the cycle `occ` hits 8; DRAIN lasts 8 cycles.
- `stall_req` held 70 cycles -> `stall` high 64 cycles, then `flush`=1 and `timeout`=1 for one cycle, `stall_count`=64, then RUN; `stall` re-asserts 1 cycle later since the request persists.
- `flush_req` and `stall_req` asserted in the same RUN cycle -> FLUSH, `flush` pulse, `stall` stays 0.
- `reset` asserted during DRAIN with `occ`=5 -> next cycle RUN, `src_ready`=1, `occ`=0, no `flush` pulse.

Source files
------------

// File: rtl/stall_mgmt_pkg.sv
// Shared types and default sizing for the global stall/flush controller.
package stall_mgmt_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int DEF_SLOTS     = 8;
    localparam int DEF_MAX_STALL = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with synchronous clear; clear beats inc beats dec.
module sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (inc && cnt != W'(MAX))
            cnt <= cnt + 1'b1;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/stall_manager.sv
// Global stall/flush controller: drives stall/flush into all buffers and
// backpressures the source while buffers fill during a stall and drain after it.
module stall_manager
    import stall_mgmt_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int SLOTS      = DEF_SLOTS,
    parameter int MAX_STALL  = DEF_MAX_STALL
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_STAGES-1:0]          stall_req,
    input  logic [NUM_STAGES-1:0]          buf_full,
    input  logic                           flush_req,
    input  logic                           src_valid,
    output logic                           stall,
    output logic                           flush,
    output logic                           src_ready,
    output logic [$clog2(MAX_STALL+1)-1:0] stall_count,
    output logic                           timeout
);

    localparam int CW = $clog2(MAX_STALL + 1);
    localparam int OW = $clog2(SLOTS + 1);

    state_t        state, next_state;
    logic [OW-1:0] occ, occ_after;
    logic          any_req;
    logic          occ_inc, occ_dec, occ_clr;
    logic          cnt_inc, cnt_clr;
    logic          timeout_n, ready_n;

    assign any_req = |stall_req;

    sat_counter #(.W(CW), .MAX(MAX_STALL)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .dec   (1'b0),
        .cnt   (stall_count)
    );

    sat_counter #(.W(OW), .MAX(SLOTS)) u_occ_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (occ_clr),
        .inc   (occ_inc),
        .dec   (occ_dec),
        .cnt   (occ)
    );

    always_comb begin
        next_state = state;
        timeout_n  = 1'b0;
        occ_dec    = 1'b0;
        // Source beats accepted while stalled pile up in the buffers.
        occ_inc    = (state == STALL) && src_valid && src_ready && (occ != OW'(SLOTS));
        occ_after  = occ + OW'(occ_inc);

        case (state)
            RUN: begin
                if (flush_req)    next_state = FLUSH;
                else if (any_req) next_state = STALL;
            end
            STALL: begin
                if (flush_req) begin
                    next_state = FLUSH;
                end else if (any_req && stall_count == CW'(MAX_STALL - 1)) begin
                    next_state = FLUSH;
                    timeout_n  = 1'b1;
                end else if (!any_req) begin
                    next_state = (occ_after != '0) ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (flush_req) begin
                    next_state = FLUSH;
                end else if (any_req) begin
                    next_state = STALL;
                end else begin
                    occ_dec = 1'b1;
                    if (occ <= OW'(1)) next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase

        // buf_full only matters while already stalled.
        case (next_state)
            RUN:     ready_n = 1'b1;
            STALL:   ready_n = !((occ_after == OW'(SLOTS)) || (state == STALL && |buf_full));
            default: ready_n = 1'b0;
        endcase

        occ_clr = (next_state == FLUSH);
        cnt_clr = (next_state == STALL) && (state != STALL);
        cnt_inc = (state == STALL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            stall     <= 1'b0;
            flush     <= 1'b0;
            timeout   <= 1'b0;
            src_ready <= 1'b1;
        end else begin
            state     <= next_state;
            stall     <= (next_state == STALL);
            flush     <= (next_state == FLUSH);
            timeout   <= timeout_n;
            src_ready <= ready_n;
        end
    end

endmodule

// File: tb/tb_stall_manager.sv
// Directed bench for stall_manager: reset, stall/drain, saturation, timeout,
// flush priority, buf_full backpressure and reset during drain.
module tb_stall_manager;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] stall_req;
    logic [3:0] buf_full;
    logic       flush_req;
    logic       src_valid;
    logic       stall;
    logic       flush;
    logic       src_ready;
    logic [6:0] stall_count;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    stall_manager #(.NUM_STAGES(4), .SLOTS(8), .MAX_STALL(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_req   (stall_req),
        .buf_full    (buf_full),
        .flush_req   (flush_req),
        .src_valid   (src_valid),
        .stall       (stall),
        .flush       (flush),
        .src_ready   (src_ready),
        .stall_count (stall_count),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; stall_req = '0; buf_full = '0; flush_req = 1'b0; src_valid = 1'b0;
        tick(); tick();
        check("rst_stall", 32'(stall), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_ready", 32'(src_ready), 1);
        check("rst_cnt", 32'(stall_count), 0);
        check("rst_tmo", 32'(timeout), 0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("idle_stall", 32'(stall), 0);
            check("idle_flush", 32'(flush), 0);
            check("idle_ready", 32'(src_ready), 1);
            check("idle_cnt", 32'(stall_count), 0);
        end

        // 3-cycle stall, 3 beats accepted, 3 drain cycles
        stall_req = 4'b0010; src_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("s3_stall", 32'(stall), 1);
            check("s3_ready", 32'(src_ready), 1);
            if (k == 3) stall_req = '0;
        end
        for (int k = 4; k <= 6; k++) begin
            tick();
            src_valid = 1'b0;
            check("s3_drain_stall", 32'(stall), 0);
            check("s3_drain_ready", 32'(src_ready), 0);
        end
        tick();
        check("s3_run_ready", 32'(src_ready), 1);
        check("s3_run_stall", 32'(stall), 0);
        check("s3_cnt", 32'(stall_count), 3);

        // 10-cycle stall: occupancy saturates at 8, drain lasts 8
        stall_req = 4'b0001; src_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("s10_stall", 32'(stall), 1);
            check("s10_ready", 32'(src_ready), 32'(k < 9));
            if (k == 10) stall_req = '0;
        end
        for (int k = 11; k <= 18; k++) begin
            tick();
            src_valid = 1'b0;
            check("s10_drain_stall", 32'(stall), 0);
            check("s10_drain_ready", 32'(src_ready), 0);
        end
        tick();
        check("s10_run_ready", 32'(src_ready), 1);
        check("s10_cnt", 32'(stall_count), 10);

        // held request: 64 stall cycles, then timeout flush, then stall again
        stall_req = 4'b1000;
        for (int k = 1; k <= 64; k++) begin
            tick();
            check("tmo_stall", 32'(stall), 1);
            check("tmo_noflush", 32'(flush), 0);
        end
        tick();
        check("tmo_flush", 32'(flush), 1);
        check("tmo_pulse", 32'(timeout), 1);
        check("tmo_stall_low", 32'(stall), 0);
        check("tmo_cnt", 32'(stall_count), 64);
        check("tmo_ready", 32'(src_ready), 0);
        tick();
        check("tmo_run_flush", 32'(flush), 0);
        check("tmo_run_pulse", 32'(timeout), 0);
        check("tmo_run_stall", 32'(stall), 0);
        check("tmo_run_ready", 32'(src_ready), 1);
        tick();
        check("tmo_restall", 32'(stall), 1);
        check("tmo_restall_cnt", 32'(stall_count), 0);
        tick(); tick(); tick();
        check("tmo_cnt3", 32'(stall_count), 3);
        stall_req = '0;
        tick();
        check("tmo_end_stall", 32'(stall), 0);
        check("tmo_end_ready", 32'(src_ready), 1);

        // flush beats stall; held flush_req flushes every other cycle
        flush_req = 1'b1; stall_req = 4'b0100;
        tick();
        check("fl_flush", 32'(flush), 1);
        check("fl_stall", 32'(stall), 0);
        check("fl_ready", 32'(src_ready), 0);
        check("fl_tmo", 32'(timeout), 0);
        stall_req = '0;
        tick();
        check("fl_gap_flush", 32'(flush), 0);
        check("fl_gap_stall", 32'(stall), 0);
        tick();
        check("fl_again", 32'(flush), 1);
        flush_req = 1'b0;
        tick();
        check("fl_end_flush", 32'(flush), 0);
        check("fl_end_ready", 32'(src_ready), 1);
        check("fl_cnt_hold", 32'(stall_count), 4);

        // buf_full drops src_ready only while stalled
        stall_req = 4'b0001; buf_full = 4'b0100; src_valid = 1'b1;
        tick();
        check("bf_stall", 32'(stall), 1);
        check("bf_ready1", 32'(src_ready), 1);
        tick();
        check("bf_ready0", 32'(src_ready), 0);
        stall_req = '0;
        tick();
        check("bf_drain_stall", 32'(stall), 0);
        check("bf_drain_ready", 32'(src_ready), 0);
        tick();
        check("bf_run_ready", 32'(src_ready), 1);
        tick();
        check("bf_ignored", 32'(src_ready), 1);
        buf_full = '0; src_valid = 1'b0;

        // reset in DRAIN with occ=5
        stall_req = 4'b0010; src_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("rd_stall", 32'(stall), 1);
            if (k == 5) stall_req = '0;
        end
        tick();
        check("rd_drain_ready", 32'(src_ready), 0);
        reset = 1'b1; src_valid = 1'b0;
        tick();
        check("rd_stall0", 32'(stall), 0);
        check("rd_flush0", 32'(flush), 0);
        check("rd_ready1", 32'(src_ready), 1);
        check("rd_cnt0", 32'(stall_count), 0);
        check("rd_tmo0", 32'(timeout), 0);
        reset = 1'b0;
        tick();
        check("rd_run_ready", 32'(src_ready), 1);
        check("rd_run_flush", 32'(flush), 0);
        stall_req = 4'b0010;
        tick();
        check("rd_probe_stall", 32'(stall), 1);
        stall_req = '0;
        tick();
        check("rd_occ_cleared", 32'(src_ready), 1);
        check("rd_probe_end", 32'(stall), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
